// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified instruction/data block-RAM path:
// port identifiers, default geometry and the read-response tag.
package cpu_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int WORDS_LOG2 = 18;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rsp_tag_t;

endpackage

// File: rtl/arb2.sv
// Two-requester grant logic for the block-RAM port: D-over-I fixed priority,
// or two-way round-robin when BRAM_ARB_RR_EN is defined.
module arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic i_req_d,
    output logic o_gnt_i,
    output logic o_gnt_d
);
    import cpu_mem_pkg::*;

    logic w_d_wins;

`ifdef BRAM_ARB_RR_EN
    logic r_last;

    // Remembers the most recent winner; starts at I so D takes the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_I;
        end else if (o_gnt_d) begin
            r_last <= PORT_D;
        end else if (o_gnt_i) begin
            r_last <= PORT_I;
        end
    end

    assign w_d_wins = i_req_d && (!i_req_i || (r_last == PORT_I));
`else
    logic w_unused;

    assign w_unused = clk;
    assign w_d_wins = i_req_d;
`endif

    // NOTE: grants are gated by rst directly; a synchronous reset would otherwise
    // let a request through during the first reset cycle.
    assign o_gnt_d = !rst && w_d_wins;
    assign o_gnt_i = !rst && i_req_i && !w_d_wins;

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port block RAM between instruction fetch (I) and load/store (D).
// Optional round-robin arbitration is enabled with the BRAM_ARB_RR_EN macro.
module bram_arbiter #(
    parameter int WORDS_LOG2 = cpu_mem_pkg::WORDS_LOG2,
    parameter int DATA_W     = cpu_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_rst,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              err_misalign,
    output logic              err_range
);
    import cpu_mem_pkg::*;

    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << (WORDS_LOG2 + 2)) - 64'd1);

    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_any;
    logic              w_out_of_range;
    logic [31:0]       w_sel_addr;
    logic [31:0]       r_addr_hold;
    logic [DATA_W-1:0] r_di_hold;
    rsp_tag_t          r_tag;
    logic              r_err_misalign;
    logic              r_err_range;

    arb2 u_arb2 (
        .clk     (clk),
        .rst     (rst),
        .i_req_i (i_req),
        .i_req_d (d_req),
        .o_gnt_i (w_gnt_i),
        .o_gnt_d (w_gnt_d)
    );

    assign i_gnt          = w_gnt_i;
    assign d_gnt          = w_gnt_d;
    assign w_any          = w_gnt_i || w_gnt_d;
    assign w_sel_addr     = w_gnt_d ? d_addr : i_addr;
    assign w_out_of_range = (w_sel_addr & ~ADDR_MASK) != 32'd0;

    // Idle cycles replay the last address/data so the RAM pins stay quiet.
    assign mem_en   = w_any;
    assign mem_we   = w_gnt_d && d_we;
    assign mem_rst  = rst;
    assign mem_addr = w_any ? (w_sel_addr & ADDR_MASK & 32'hFFFF_FFFC) : r_addr_hold;
    assign mem_di   = w_any ? d_wdata : r_di_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag          <= '0;
            r_addr_hold    <= '0;
            r_di_hold      <= '0;
            r_err_misalign <= 1'b0;
            r_err_range    <= 1'b0;
        end else begin
            r_tag <= w_any ? '{valid: 1'b1, port: (w_gnt_d ? PORT_D : PORT_I)} : '0;
            if (w_any) begin
                r_addr_hold <= mem_addr;
                r_di_hold   <= mem_di;
            end
            if (w_gnt_d && (d_addr[1:0] != 2'b00)) begin
                r_err_misalign <= 1'b1;
            end
            if (w_any && w_out_of_range) begin
                r_err_range <= 1'b1;
            end
        end
    end

    assign i_rvalid     = !rst && r_tag.valid && (r_tag.port == PORT_I);
    assign d_rvalid     = !rst && r_tag.valid && (r_tag.port == PORT_D);
    assign i_rdata      = mem_dout;
    assign d_rdata      = mem_dout;
    assign err_misalign = r_err_misalign;
    assign err_range    = r_err_range;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed and randomised checks of bram_arbiter against a behavioural RAM
// and a small reference memory; arbitration expectations follow BRAM_ARB_RR_EN.
module tb_bram_arbiter;

    localparam int WL2 = 18;
    localparam int DW  = 32;
`ifdef BRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic          mem_rst;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_dout;
    logic          err_misalign;
    logic          err_range;

    int checks = 0;
    int errors = 0;

    bram_arbiter #(.WORDS_LOG2(WL2), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_rst      (mem_rst),
        .mem_addr     (mem_addr),
        .mem_di       (mem_di),
        .mem_dout     (mem_dout),
        .err_misalign (err_misalign),
        .err_range    (err_range)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: unwritten word k reads as 0xA0000000 + k; read-first.
    logic [31:0] ram [0:(1<<WL2)-1];
    bit          ram_wr [0:(1<<WL2)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[WL2+1:2]]    <= mem_di;
                ram_wr[mem_addr[WL2+1:2]] <= 1'b1;
            end
            mem_dout <= ram_wr[mem_addr[WL2+1:2]] ? ram[mem_addr[WL2+1:2]]
                                                  : 32'hA000_0000 + 32'(mem_addr[WL2+1:2]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ref_mem [0:15];
    logic        exp_gd, exp_i_rv, exp_d_rv, exp_d_load, g_i, g_d, tb_last, exp_d_k;
    logic [31:0] exp_i_data, exp_d_data;

    initial begin
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state, including a request that must not be granted.
        @(negedge clk);
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_err_mis", err_misalign, 0);
        check("rst_err_rng", err_range, 0);
        check("rst_mem_rst", mem_rst, 1);
        check("rst_mem_en", mem_en, 0);
        tick();
        rst = 1'b0;

        // Fetch-only stream of three requests.
        @(negedge clk);
        check("f1_i_gnt", i_gnt, 1);
        check("f1_mem_en", mem_en, 1);
        check("f1_mem_addr", mem_addr, 32'h100);
        check("f1_mem_we", mem_we, 0);
        check("f1_i_rvalid", i_rvalid, 0);
        check("f1_d_gnt", d_gnt, 0);
        tick();
        @(negedge clk);
        check("f2_i_gnt", i_gnt, 1);
        check("f2_i_rvalid", i_rvalid, 1);
        check("f2_i_rdata", i_rdata, 32'hA000_0040);
        check("f2_d_rvalid", d_rvalid, 0);
        tick();
        @(negedge clk);
        check("f3_i_gnt", i_gnt, 1);
        check("f3_i_rvalid", i_rvalid, 1);
        check("f3_i_rdata", i_rdata, 32'hA000_0040);
        tick();
        i_req = 1'b0;
        @(negedge clk);
        check("f4_i_gnt", i_gnt, 0);
        check("f4_i_rvalid", i_rvalid, 1);
        check("f4_i_rdata", i_rdata, 32'hA000_0040);
        check("f4_mem_en", mem_en, 0);
        check("f4_mem_addr_hold", mem_addr, 32'h100);
        tick();

        // Store then load of the same word.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("st_d_gnt", d_gnt, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 32'h20);
        check("st_mem_di", mem_di, 32'hDEAD_BEEF);
        check("st_i_rvalid", i_rvalid, 0);
        tick();
        d_we = 1'b0;
        @(negedge clk);
        check("ld_d_gnt", d_gnt, 1);
        check("ld_mem_we", mem_we, 0);
        check("st_ack_rvalid", d_rvalid, 1);
        tick();
        d_req = 1'b0; d_wdata = '0;
        @(negedge clk);
        check("ld_d_rvalid", d_rvalid, 1);
        check("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("idle_mem_en", mem_en, 0);
        check("idle_mem_di_hold", mem_di, 32'hDEAD_BEEF);
        tick();

        // Grant immediately followed by reset: the response is dropped.
        d_req = 1'b1;
        @(negedge clk);
        check("pre_rst_d_gnt", d_gnt, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_d_gnt", d_gnt, 0);
        check("mid_rst_d_rvalid", d_rvalid, 0);
        check("mid_rst_i_rvalid", i_rvalid, 0);
        check("mid_rst_mem_en", mem_en, 0);
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_mem_rst", mem_rst, 1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        check("mid_rst2_d_rvalid", d_rvalid, 0);
        tick();
        rst = 1'b0;

        // Both ports requesting for four cycles.
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        exp_d_k = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("cf_d_rvalid", d_rvalid, exp_d_k);
                check("cf_i_rvalid", i_rvalid, !exp_d_k);
            end
            exp_d_k = RR ? ((k % 2) == 0) : 1'b1;
            check("cf_d_gnt", d_gnt, exp_d_k);
            check("cf_i_gnt", i_gnt, !exp_d_k);
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("cf_last_d_rvalid", d_rvalid, exp_d_k);
        check("cf_last_i_rvalid", i_rvalid, !exp_d_k);
        tick();

        // Misaligned and range-boundary accesses.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h22;
        @(negedge clk);
        check("mis_d_gnt", d_gnt, 1);
        check("mis_mem_addr", mem_addr, 32'h20);
        check("mis_err_before", err_misalign, 0);
        tick();
        d_addr = 32'h000F_FFFC;
        @(negedge clk);
        check("mis_err_set", err_misalign, 1);
        check("mis_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("top_mem_addr", mem_addr, 32'h000F_FFFC);
        tick();
        d_addr = 32'h0010_0000;
        @(negedge clk);
        check("top_err_rng", err_range, 0);
        check("top_d_rdata", d_rdata, 32'hA003_FFFF);
        check("oor_mem_addr", mem_addr, 32'h0);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        check("oor_err_rng", err_range, 1);
        check("oor_d_rdata", d_rdata, 32'hA000_0000);
        tick();
        @(negedge clk);
        check("mis_sticky", err_misalign, 1);
        check("rng_sticky", err_range, 1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("clr_err_mis", err_misalign, 0);
        check("clr_err_rng", err_range, 0);
        tick();
        rst = 1'b0;

        // Random traffic over the first 16 words against a reference memory.
        for (int k = 0; k < 16; k++) ref_mem[k] = 32'hA000_0000 + 32'(k);
        ref_mem[8] = 32'hDEAD_BEEF;
        exp_i_rv = 1'b0; exp_d_rv = 1'b0; exp_d_load = 1'b0;
        g_i = 1'b0; g_d = 1'b0; tb_last = 1'b0;
        exp_i_data = '0; exp_d_data = '0;
        for (int n = 0; n < 10000; n++) begin
            if (!(i_req && !g_i)) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!(d_req && !g_d)) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
            @(negedge clk);
            exp_gd = d_req && (!i_req || !RR || !tb_last);
            check("rnd_d_gnt", d_gnt, exp_gd);
            check("rnd_i_gnt", i_gnt, i_req && !exp_gd);
            check("rnd_i_rvalid", i_rvalid, exp_i_rv);
            check("rnd_d_rvalid", d_rvalid, exp_d_rv);
            if (exp_i_rv) check("rnd_i_rdata", i_rdata, exp_i_data);
            if (exp_d_rv && exp_d_load) check("rnd_d_rdata", d_rdata, exp_d_data);
            exp_i_rv = i_req && !exp_gd;
            exp_d_rv = exp_gd;
            if (exp_gd) begin
                if (d_we) begin
                    ref_mem[d_addr[5:2]] = d_wdata;
                    exp_d_load = 1'b0;
                end else begin
                    exp_d_data = ref_mem[d_addr[5:2]];
                    exp_d_load = 1'b1;
                end
                tb_last = 1'b1;
            end else if (i_req) begin
                exp_i_data = ref_mem[i_addr[5:2]];
                tb_last = 1'b0;
            end
            g_i = i_req && !exp_gd;
            g_d = exp_gd;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-port unified instruction/data block RAM between the instruction-fetch requester (I-port) and the load/store requester (D-port).
- Grants at most one access per cycle and drives the RAM port (en/we/rst/addr/di).
- Routes the 1-cycle-latency RAM read data back to the requester that was granted.
- Flags misaligned and out-of-range data accesses.

Parameters:
- WORDS_LOG2, 18, log2 of RAM depth in 32-bit words. Legal byte address range is 0 .. 2^(WORDS_LOG2+2)-1.
- DATA_W, 32, word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid; one cycle after i_gnt
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  data response (load data or store ack); one cycle after d_gnt
- d_rdata  out  DATA_W  load data; value undefined for stores
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_rst  out  1  RAM output-register reset
- mem_addr  out  32  RAM byte address (RAM indexes addr[31:2])
- mem_di  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM registered read data
- err_misalign  out  1  sticky: granted D access with d_addr[1:0]!=0
- err_range  out  1  sticky: granted I or D access with addr >= 2^(WORDS_LOG2+2)

Behaviour:
- Reset values: all grant and rvalid outputs 0, err flags 0, priority pointer selects D, response-tag register cleared. mem_rst = rst.
- Grants are combinational from req and arbitration state. Exactly one of i_gnt/d_gnt may be asserted per cycle, and neither while rst=1.
- Arbitration, default build: fixed priority, D over I. I is granted only when d_req=0.
- Granted cycle:
  - mem_en=1.
  - mem_addr = granted addr with bits [1:0] forced to 0.
  - mem_we = d_we when D is granted, else 0.
  - mem_di = d_wdata.
- No grant: mem_en=0, mem_we=0. mem_addr and mem_di hold the last value (no toggling).
- Response tag register {valid, port} is loaded on every grant and cleared otherwise.
- Cycle after a grant: the tagged port's rvalid=1 and its rdata = mem_dout. The other port's rvalid=0.
- rdata is combinational from mem_dout and is only meaningful while rvalid=1.
- Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle and latency is 1.
- Out-of-range access: still performed with the address truncated to WORDS_LOG2 word bits, and err_range is set.
- Misaligned D access: performed on the aligned word, and err_misalign is set. Err flags clear only on rst.
- Simultaneous i_req and d_req: resolved per arbitration policy; the loser keeps its req asserted.
- Reset mid-operation: a grant issued in the cycle before rst=1 gets no rvalid. Any rvalid is suppressed while rst=1.
- Requester dropping req without a grant: allowed, no side effects.

Optional Feature:
- Macro: BRAM_ARB_RR_EN.
- Defined: two-way round-robin.
  - When both request, grant the port not granted most recently.
  - Single-bit last-grant register, reset to I, so D wins the first conflict.
  - The pointer updates only on a grant.
- Undefined: fixed D-over-I priority as above. No pointer register is synthesised.

Decomposition:
- Shared package cpu_mem_pkg:
  - port-ID constants PORT_I=0, PORT_D=1
  - DATA_W, WORDS_LOG2
  - response-tag struct {valid, port}
- Natural sub-module: arb2 (two-requester grant logic, fixed/RR selected by the macro). Everything else is flat in bram_arbiter.

Test Plan:
- Only i_req, i_addr=0x100, for 3 cycles: i_gnt each cycle, i_rvalid in cycles 2-4 with the RAM words at indices 0x40/0x40/0x40. d_* stays idle.
- d_req store d_addr=0x20, d_wdata=0xDEADBEEF, then a load of 0x20 the next cycle: d_gnt both cycles, mem_we=1 then 0. The second d_rvalid returns 0xDEADBEEF.
- i_req and d_req both held 4 cycles, default build: d_gnt ×4, i_gnt 0. With BRAM_ARB_RR_EN: grants alternate D,I,D,I.
- d_addr=0x22 load: access to word 0x8, err_misalign=1 and stays 1 until rst. d_addr=0x0010_0000 with WORDS_LOG2=18: err_range=1.
- Grant in cycle N, rst=1 in cycle N+1: no rvalid in N+1, all outputs at reset values, mem_rst=1.
- Random req/we/addr for 10k cycles against a reference memory model: every granted load returns the last stored value, at most one gnt per cycle, and every gnt is followed by exactly one rvalid on the same port.
